// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, credit-limited imem requests, response FIFO to decode.
// Optional perf counters (perf_fetched_o / perf_flushed_o) are built when FETCH_PERF_CNT_EN is defined.
package pc_mux_pkg;
  typedef enum logic [1:0] {
    SEL_PC_NONE   = 2'd0,
    SEL_PC_PLUS4  = 2'd1,
    SEL_PC_BRANCH = 2'd2,
    SEL_PC_JUMP   = 2'd3
  } sel_pc_t;
endpackage

module fetch_unit
  import pc_mux_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_stall_i,
  input  logic [1:0]  pc_sel_i,
  input  logic        br_taken_i,
  input  logic [31:0] next_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_flushed_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_ent_t;

  // Both queues are shift registers with the head at index 0.
  fq_ent_t [FIFO_DEPTH-1:0]        fq_q, fq_d;
  logic    [FIFO_DEPTH-1:0][31:0]  tag_q, tag_d;
  logic    [CW-1:0] fcnt_q, fcnt_d, outst_q, outst_d, drop_q, drop_d;
  logic    [CW-1:0] fq_wr_idx, tag_wr_idx;
  logic    [31:0]   pc_q, pc_d;

  logic redirect, credit_ok, req, acc, rsp, drop_rsp, push, pop;
  logic unused_pc_lo;

  assign unused_pc_lo = ^next_pc_i[1:0];

  assign redirect  = (pc_sel_i == SEL_PC_JUMP) |
                     ((pc_sel_i == SEL_PC_BRANCH) & br_taken_i);
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fcnt_q}) < DEPTH_C;
  assign req       = ~rst & ~fetch_stall_i & ~redirect & credit_ok;
  assign acc       = req & imem_ready_i;
  assign rsp       = imem_rvalid_i & (outst_q != '0);
  // A response landing in the redirect cycle belongs to the old path too.
  assign drop_rsp  = rsp & (redirect | (drop_q != '0));
  assign push      = rsp & ~drop_rsp;
  assign pop       = (fcnt_q != '0) & inst_ready_i & ~redirect;

  assign fq_wr_idx  = fcnt_q - CW'(pop);
  assign tag_wr_idx = outst_q - CW'(rsp);

  always_comb begin
    fq_d   = fq_q;
    fcnt_d = fcnt_q;
    if (redirect) begin
      fcnt_d = '0;
    end else begin
      // Shift only when another entry follows, so an emptied head keeps its last value.
      if (pop && fcnt_q > CW'(1)) begin
        for (int i = 0; i < FIFO_DEPTH-1; i++) fq_d[i] = fq_q[i+1];
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push && fq_wr_idx == CW'(i)) fq_d[i] = '{inst: imem_rdata_i, pc: tag_q[0]};
      end
      fcnt_d = fcnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    tag_d = tag_q;
    if (rsp) begin
      for (int i = 0; i < FIFO_DEPTH-1; i++) tag_d[i] = tag_q[i+1];
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (acc && tag_wr_idx == CW'(i)) tag_d[i] = pc_q;
    end
    outst_d = outst_q + CW'(acc) - CW'(rsp);
  end

  always_comb begin
    drop_d = drop_q;
    pc_d   = pc_q;
    if (redirect) begin
      drop_d = outst_q - CW'(rsp);
      pc_d   = {next_pc_i[31:2], 2'b00};
    end else begin
      if (rsp && drop_q != '0) drop_d = drop_q - CW'(1);
      if (acc) pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fq_q    <= '0;
      tag_q   <= '0;
      fcnt_q  <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      fq_q    <= fq_d;
      tag_q   <= tag_d;
      fcnt_q  <= fcnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = (fcnt_q != '0);
  assign inst_o       = fq_q[0].inst;
  assign inst_pc_o    = fq_q[0].pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, flushed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(pop);
      flushed_q <= flushed_q + (redirect ? 32'(fcnt_q) : 32'd0) + 32'(drop_rsp);
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_flushed_o = flushed_q;
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model with an in-order memory.
module tb_fetch_unit;
  import pc_mux_pkg::*;

  localparam logic [31:0] RPC = 32'h100;
  localparam int          D   = 2;

  logic        clk = 1'b0;
  logic        rst, stall, br, ready, rvalid, iready;
  logic [1:0]  sel;
  logic [31:0] nxt, rdata;
  logic        req_o, valid_o;
  logic [31:0] addr_o, inst_o, ipc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_f, perf_x;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .fetch_stall_i(stall), .pc_sel_i(sel), .br_taken_i(br),
    .next_pc_i(nxt), .imem_req_o(req_o), .imem_addr_o(addr_o), .imem_ready_i(ready),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .inst_valid_o(valid_o), .inst_o(inst_o),
    .inst_pc_o(ipc_o), .inst_ready_i(iready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched_o(perf_f), .perf_flushed_o(perf_x)
`endif
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // Reference state: FIFO contents, in-flight request addresses, responses still to discard.
  ent_t        fifo[$];
  logic [31:0] infl[$];
  int          drop;
  logic [31:0] pc_m, sh_inst, sh_pc, tagpc;
  int unsigned m_fetched, m_flushed;
  bit          redir, e_req, e_valid, acc, rsp, pop;
  int          rp, sp, r;

  initial begin
    pc_m = RPC; drop = 0; sh_inst = '0; sh_pc = '0; m_fetched = 0; m_flushed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; br = 1'($urandom); nxt = $urandom;
      sel = ($urandom_range(1) == 1) ? SEL_PC_PLUS4 : SEL_PC_NONE;
      ready = 1'b1; iready = 1'b1; rp = 100; sp = 0;
      if (cyc < 2) rst = 1'b1;
      else if (cyc >= 15 && cyc < 27) iready = 1'b0;
      else if (cyc >= 31 && cyc < 37) stall = 1'b1;
      else if (cyc >= 39 && cyc <= 41) begin
        rp = 0;
        if (cyc == 41) begin sel = SEL_PC_JUMP; nxt = 32'h203; end
      end
      else if (cyc >= 50 && cyc < 56) begin sel = SEL_PC_BRANCH; br = 1'b0; end
      else if (cyc == 60) begin sel = SEL_PC_JUMP; nxt = 32'hFFFF_FFF6; end
      else if (cyc == 72) rst = 1'b1;
      else if (cyc >= 80) begin
        stall  = ($urandom_range(99) < 20);
        ready  = ($urandom_range(99) < 70);
        iready = ($urandom_range(99) < 60);
        rp = 60; sp = 5;
        r = $urandom_range(99);
        if (r < 3) sel = SEL_PC_JUMP;
        else if (r < 13) sel = SEL_PC_BRANCH;
        if ($urandom_range(99) == 0) rst = 1'b1;
        if ($urandom_range(99) < 5) nxt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      end
      if (infl.size() > 0) begin
        rvalid = ($urandom_range(99) < rp);
        rdata  = memf(infl[0]);
      end else begin
        rvalid = ($urandom_range(99) < sp);
        rdata  = $urandom;
      end
      #1;
      redir   = (sel == SEL_PC_JUMP) || (sel == SEL_PC_BRANCH && br);
      e_req   = !rst && !stall && !redir && (infl.size() + fifo.size() < D);
      e_valid = (fifo.size() > 0);
      if (cyc > 0) begin
        chk("imem_req", 32'(req_o), 32'(e_req));
        chk("imem_addr", addr_o, pc_m);
        chk("inst_valid", 32'(valid_o), 32'(e_valid));
        chk("inst", inst_o, sh_inst);
        chk("inst_pc", ipc_o, sh_pc);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_f, m_fetched);
        chk("perf_flushed", perf_x, m_flushed);
`endif
      end
      if (rst) begin
        pc_m = RPC; fifo.delete(); infl.delete(); drop = 0;
        sh_inst = '0; sh_pc = '0; m_fetched = 0; m_flushed = 0;
      end else begin
        acc = e_req && ready;
        rsp = rvalid && (infl.size() > 0);
        pop = e_valid && iready && !redir;
        if (redir) m_flushed += fifo.size();
        if (pop) begin
          void'(fifo.pop_front());
          m_fetched++;
        end
        if (rsp) begin
          tagpc = infl.pop_front();
          if (redir || drop > 0) begin
            m_flushed++;
            if (!redir) drop--;
          end else fifo.push_back('{inst: memf(tagpc), pc: tagpc});
        end
        if (redir) begin
          fifo.delete();
          drop = infl.size();
          pc_m = {nxt[31:2], 2'b00};
        end else if (acc) begin
          infl.push_back(pc_m);
          pc_m = pc_m + 32'd4;
        end
        if (fifo.size() > 0) begin
          sh_inst = fifo[0].inst;
          sh_pc   = fifo[0].pc;
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
